// File: rtl/conv25_feeder_pkg.sv
// rtl/conv25_feeder_pkg.sv - shared types and constants for the conv25 feeder
package conv25_feeder_pkg;

    localparam int TAPS   = 25;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        CLEAR,
        STREAM,
        FLUSH
    } state_t;

endpackage

// File: rtl/conv25_feeder_if.sv
// rtl/conv25_feeder_if.sv - control, SRAM and array signals of the conv25 feeder
interface conv25_feeder_if #(
    parameter int ADDR_W = 16
);
    import conv25_feeder_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              w_req;
    logic [4:0]        w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_rdata;
    logic [DATA_W-1:0] w_in;
    logic              w_en;
    logic [DATA_W-1:0] d_in;
    logic              z_en;
    logic [ACC_W-1:0]  ans_out;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;

    modport master (
        input  start, w_rdata, d_rdata, ans_out,
        output busy, done, w_req, w_addr, d_req, d_addr,
               w_in, w_en, d_in, z_en, res_valid, res_data
    );

    modport slave (
        output start, w_rdata, d_rdata, ans_out,
        input  busy, done, w_req, w_addr, d_req, d_addr,
               w_in, w_en, d_in, z_en, res_valid, res_data
    );

endinterface

// File: rtl/conv25_feeder_valid_delay.sv
// rtl/conv25_feeder_valid_delay.sv - 1-bit shift register matching the array latency
module conv25_feeder_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv25_feeder.sv
// rtl/conv25_feeder.sv - loads 25 weights, clears, streams pixels and captures array results
module conv25_feeder
    import conv25_feeder_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NUM_PIX   = 1024,
    parameter int ARRAY_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    conv25_feeder_if.master bus
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST_W     = CW'(TAPS);
    localparam logic [CW-1:0] LAST_PIX   = CW'(NUM_PIX - 1);
    localparam logic [CW-1:0] LAST_FL    = CW'(ARRAY_LAT);
    localparam logic [CW-1:0] FIRST_FULL = CW'(TAPS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             start_prev_q, start_prev_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [CW-1:0]    next_cnt;
    logic             tag_in;
    logic             tag_out;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        start_prev_d = bus.start;
        tag_in       = 1'b0;
        next_cnt     = cnt_q + 1'b1;
        bus.w_req    = 1'b0;
        bus.w_addr   = '0;
        bus.w_en     = 1'b0;
        bus.w_in     = '0;
        bus.d_req    = 1'b0;
        bus.d_addr   = '0;
        bus.d_in     = '0;
        bus.z_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Rising edge only, and not in the done cycle: a held start runs once.
                if (bus.start && !start_prev_q && !done_q) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (cnt_q < LAST_W) begin
                    bus.w_req  = 1'b1;
                    bus.w_addr = cnt_q[4:0];
                end
                // SRAM data for address k-1 arrives in step k.
                if (cnt_q != '0) begin
                    bus.w_en = 1'b1;
                    bus.w_in = bus.w_rdata;
                end
                if (cnt_q == LAST_W) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = next_cnt;
                end
            end
            CLEAR: begin
                bus.z_en   = 1'b1;
                bus.d_req  = 1'b1;
                bus.d_addr = '0;
                state_d    = STREAM;
                cnt_d      = '0;
            end
            STREAM: begin
                bus.d_in = bus.d_rdata;
                tag_in   = (cnt_q >= FIRST_FULL);
                if (cnt_q < LAST_PIX) begin
                    bus.d_req  = 1'b1;
                    bus.d_addr = next_cnt[ADDR_W-1:0];
                    cnt_d      = next_cnt;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == LAST_FL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = next_cnt;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    conv25_feeder_valid_delay #(.DEPTH(ARRAY_LAT)) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign res_valid_d = tag_out;
    assign res_data_d  = bus.ans_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            start_prev_q <= start_prev_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
        end
    end

    assign bus.busy      = (state_q != IDLE) || done_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_conv25_feeder.sv
// tb/tb_conv25_feeder.sv - directed bench over three feeder configurations
module tb_conv25_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic       mon_clr;
    logic [7:0] wmem [25];
    logic [7:0] pmem [64];
    int         exp_res;
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int NP  = (g == 0) ? 30 : ((g == 1) ? 25 : 40);
        localparam int LAT = (g == 2) ? 3 : 1;

        conv25_feeder_if #(.ADDR_W(16)) ifc ();

        conv25_feeder #(.ADDR_W(16), .NUM_PIX(NP), .ARRAY_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.master)
        );

        assign ifc.start = start_v[g];

        logic [75:0] outs;
        assign outs = {ifc.busy, ifc.done, ifc.w_req, ifc.w_addr, ifc.d_req, ifc.d_addr,
                       ifc.w_in, ifc.w_en, ifc.d_in, ifc.z_en, ifc.res_valid, ifc.res_data};

        always @(posedge clk) begin
            if (rst) begin
                ifc.w_rdata <= '0;
                ifc.d_rdata <= '0;
            end else begin
                if (ifc.w_req && ifc.w_addr < 5'd25) ifc.w_rdata <= wmem[ifc.w_addr];
                if (ifc.d_req) ifc.d_rdata <= pmem[ifc.d_addr[5:0]];
            end
        end

        logic [7:0] wsr  [25];
        logic [7:0] hist [24];
        int         pipe [LAT];
        int         win_sum;

        always_comb begin
            win_sum = sx(ifc.d_in) * sx(wsr[0]);
            for (int k = 1; k < 25; k++) win_sum += sx(hist[k-1]) * sx(wsr[k]);
        end

        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 25; k++) wsr[k] <= '0;
                for (int k = 0; k < 24; k++) hist[k] <= '0;
                for (int i = 0; i < LAT; i++) pipe[i] <= 0;
            end else begin
                if (ifc.w_en) begin
                    wsr[0] <= ifc.w_in;
                    for (int k = 1; k < 25; k++) wsr[k] <= wsr[k-1];
                end
                if (ifc.z_en) begin
                    for (int k = 0; k < 24; k++) hist[k] <= '0;
                    pipe[0] <= 0;
                end else begin
                    hist[0] <= ifc.d_in;
                    for (int k = 1; k < 24; k++) hist[k] <= hist[k-1];
                    pipe[0] <= win_sum;
                end
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign ifc.ans_out = 32'(pipe[LAT-1]);

        int cyc = 0;
        int wen_cnt, wen_first, wen_last, win_err, z_cnt, z_cyc;
        int rv_cnt, rv_first, rv_last, rv_bad, done_cnt, done_cyc;
        int dmax, dbad, ovl, runs;
        logic [24:0] wseen;
        logic        busy_p;

        always @(negedge clk) begin
            cyc <= cyc + 1;
            if (mon_clr) begin
                wen_cnt <= 0; wen_first <= 0; wen_last <= 0; win_err <= 0;
                z_cnt <= 0; z_cyc <= 0; rv_cnt <= 0; rv_first <= 0; rv_last <= 0;
                rv_bad <= 0; done_cnt <= 0; done_cyc <= 0; dmax <= 0; dbad <= 0;
                ovl <= 0; runs <= 0; wseen <= '0; busy_p <= ifc.busy;
            end else begin
                if (ifc.w_en) begin
                    if (wen_cnt == 0) wen_first <= cyc;
                    wen_last <= cyc;
                    if (wen_cnt >= 25 || ifc.w_in !== wmem[wen_cnt % 25]) win_err <= win_err + 1;
                    wen_cnt <= wen_cnt + 1;
                end
                if (ifc.w_req && ifc.w_addr < 5'd25) wseen[ifc.w_addr] <= 1'b1;
                if (ifc.z_en) begin
                    z_cnt <= z_cnt + 1;
                    z_cyc <= cyc;
                end
                if (ifc.res_valid) begin
                    if (rv_cnt == 0) rv_first <= cyc;
                    rv_last <= cyc;
                    if (ifc.res_data !== 32'(exp_res)) rv_bad <= rv_bad + 1;
                    rv_cnt <= rv_cnt + 1;
                end
                if (ifc.done) begin
                    done_cnt <= done_cnt + 1;
                    done_cyc <= cyc;
                end
                if (ifc.d_req) begin
                    if (int'(ifc.d_addr) > dmax) dmax <= int'(ifc.d_addr);
                    if (int'(ifc.d_addr) >= NP) dbad <= dbad + 1;
                end
                if (ifc.w_en && ifc.d_in != 8'd0) ovl <= ovl + 1;
                busy_p <= ifc.busy;
                if (ifc.busy && !busy_p) runs <= runs + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run(input int g);
        @(negedge clk);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic set_mem(input int wmode, input int pmode);
        for (int k = 0; k < 25; k++) wmem[k] = (wmode == 1) ? 8'(k + 1) : 8'd1;
        for (int j = 0; j < 64; j++) pmem[j] = (pmode == 1) ? 8'(j + 1) : 8'd1;
    endtask

    initial begin
        bit found;
        rst = 1'b1; start_v = '0; mon_clr = 1'b0; exp_res = 0;
        set_mem(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_outs_a", cfg[0].outs, 0);
        chk("rst_outs_c", cfg[2].outs, 0);
        rst = 1'b0;
        clr_mon();

        // weights k+1, pixels 1: each full window sums the weights, 325
        set_mem(1, 0); exp_res = 325;
        start_run(0);
        for (int i = 0; i < 2000 && cfg[0].done_cnt == 0; i++) @(negedge clk);
        chk("t1_wen_cnt", cfg[0].wen_cnt, 25);
        chk("t1_wen_span", cfg[0].wen_last - cfg[0].wen_first, 24);
        chk("t1_w_in_seq", cfg[0].win_err, 0);
        chk("t1_w_addr_cover", cfg[0].wseen, 25'h1ff_ffff);
        chk("t1_z_cnt", cfg[0].z_cnt, 1);
        chk("t1_z_after_wen", cfg[0].z_cyc - cfg[0].wen_last, 1);
        chk("t1_rv_cnt", cfg[0].rv_cnt, 6);
        chk("t1_rv_data", cfg[0].rv_bad, 0);
        chk("t1_overlap", cfg[0].ovl, 0);
        repeat (3) @(negedge clk);
        clr_mon();

        set_mem(0, 0); exp_res = 25;
        start_run(0);
        for (int i = 0; i < 2000 && cfg[0].done_cnt == 0; i++) @(negedge clk);
        chk("t2_done_cnt", cfg[0].done_cnt, 1);
        @(negedge clk);
        chk("t2_busy_after", cfg[0].ifc.busy, 0);
        chk("t2_rv_cnt", cfg[0].rv_cnt, 6);
        chk("t2_rv_data", cfg[0].rv_bad, 0);
        chk("t2_rv_first", cfg[0].rv_first - cfg[0].z_cyc, 27);
        chk("t2_rv_consec", cfg[0].rv_last - cfg[0].rv_first, 5);
        chk("t2_done_after_rv", cfg[0].done_cyc - cfg[0].rv_last, 1);
        chk("t2_dmax", cfg[0].dmax, 29);
        chk("t2_dbad", cfg[0].dbad, 0);
        clr_mon();

        // NUM_PIX=25, pixels j+1, start held across the whole run and past done
        set_mem(0, 1); exp_res = 325;
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int i = 0; i < 2000 && cfg[1].done_cnt == 0; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        chk("t3_runs_held", cfg[1].runs, 1);
        chk("t3_rv_cnt", cfg[1].rv_cnt, 1);
        chk("t3_rv_data", cfg[1].rv_bad, 0);
        chk("t3_dmax", cfg[1].dmax, 24);
        chk("t3_dbad", cfg[1].dbad, 0);
        start_v[1] = 1'b0;
        start_run(1);
        for (int i = 0; i < 2000 && cfg[1].done_cnt < 2; i++) @(negedge clk);
        chk("t3_runs_second", cfg[1].runs, 2);
        chk("t3_done_second", cfg[1].done_cnt, 2);
        clr_mon();

        // reset while pixel 10 is on d_in
        set_mem(0, 0); exp_res = 25;
        start_run(0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (cfg[0].ifc.d_req && cfg[0].ifc.d_addr == 16'd11) found = 1'b1;
            else @(negedge clk);
        end
        chk("t4_reached_px10", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_outs_zero", cfg[0].outs, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_no_done", cfg[0].done_cnt, 0);
        chk("t4_no_rv", cfg[0].rv_cnt, 0);
        chk("t4_idle", cfg[0].ifc.busy, 0);
        clr_mon();
        start_run(0);
        for (int i = 0; i < 2000 && cfg[0].done_cnt == 0; i++) @(negedge clk);
        chk("t4_rerun_wen", cfg[0].wen_cnt, 25);
        chk("t4_rerun_rv", cfg[0].rv_cnt, 6);
        chk("t4_rerun_data", cfg[0].rv_bad, 0);
        clr_mon();

        // ARRAY_LAT=3, NUM_PIX=40
        start_run(2);
        for (int i = 0; i < 2000 && cfg[2].done_cnt == 0; i++) @(negedge clk);
        chk("t5_done_cnt", cfg[2].done_cnt, 1);
        chk("t5_rv_cnt", cfg[2].rv_cnt, 16);
        chk("t5_rv_first", cfg[2].rv_first - cfg[2].z_cyc, 29);
        chk("t5_rv_consec", cfg[2].rv_last - cfg[2].rv_first, 15);
        chk("t5_done_after_rv", cfg[2].done_cyc - cfg[2].rv_last, 1);
        chk("t5_rv_data", cfg[2].rv_bad, 0);
        chk("t5_dmax", cfg[2].dmax, 39);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
